// File: rtl/imem_boot_sequencer.sv
// Boot loader and fetch arbiter for the tile instruction memory.
// Optional macro IMEM_RELOAD_EN: reload_req in RUN restarts a load.
module imem_boot_sequencer #(
   parameter int ADDR_W         = 10,
   parameter int DATA_W         = 32,
   parameter int LOAD_WORDS     = 1024,
   parameter int RELEASE_CYCLES = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_gnt,
   output logic              fetch_rvalid,
   output logic [DATA_W-1:0] fetch_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              reload_req,
   output logic              core_reset,
   output logic              load_done,
   output logic              load_err,
   output logic [ADDR_W:0]   loaded_words
);

   typedef enum logic [1:0] {
      S_LOAD,
      S_HOLD,
      S_RUN,
      S_ERR
   } state_e;

   localparam int HC_W = $clog2(RELEASE_CYCLES + 1);
   localparam logic [ADDR_W:0] LAST_IDX =
      (ADDR_W + 1)'(LOAD_WORDS - 1);
   localparam logic [HC_W-1:0] HOLD_END =
      HC_W'(RELEASE_CYCLES - 1);

   state_e            state_q, state_d;
   logic [ADDR_W:0]   wptr_q, wptr_d;
   logic [HC_W-1:0]   hcnt_q, hcnt_d;
   logic              rvalid_q, rvalid_d;
   logic              err_q, err_d;
   logic              accept;
   logic              reload;

`ifdef IMEM_RELOAD_EN
   assign reload = reload_req & (state_q == S_RUN);
`else
   logic unused_reload;
   assign reload        = 1'b0;
   assign unused_reload = reload_req;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_LOAD: begin
            if (accept) begin
               if (ld_last) begin
                  state_d = S_HOLD;
               end else if (wptr_q == LAST_IDX) begin
                  state_d = S_ERR;
               end
            end
         end
         S_HOLD: begin
            if (hcnt_q == HOLD_END) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (reload) begin
               state_d = S_LOAD;
            end
         end
         S_ERR: begin
            state_d = S_ERR;
         end
         default: begin
            state_d = S_ERR;
         end
      endcase
   end

   always_comb begin
      ld_ready   = (state_q == S_LOAD);
      accept     = ld_valid & ld_ready;
      fetch_gnt  = (state_q == S_RUN) & fetch_req & ~reload;
      mem_en     = accept | fetch_gnt;
      mem_we     = accept;
      mem_addr   = accept ? wptr_q[ADDR_W-1:0] : fetch_addr;
      mem_wdata  = ld_data;
      core_reset = (state_q != S_RUN);
      load_done  = (state_q == S_RUN);
   end

   always_comb begin
      wptr_d = wptr_q;
      if (accept) begin
         wptr_d = wptr_q + 1'b1;
      end
      if (reload) begin
         wptr_d = '0;
      end
      // Counter only runs in HOLD so it is zero on every HOLD entry.
      hcnt_d   = (state_q == S_HOLD) ? hcnt_q + 1'b1 : '0;
      err_d    = err_q | (state_d == S_ERR);
      rvalid_d = fetch_gnt;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wptr_q   <= '0;
         hcnt_q   <= '0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         hcnt_q   <= hcnt_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
      end
   end

   assign fetch_rvalid = rvalid_q;
   assign fetch_rdata  = mem_rdata;
   assign load_err     = err_q;
   assign loaded_words = wptr_q;

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// Scoreboard bench for imem_boot_sequencer with a behavioural
// sync-read memory; checks write order, read data and handshakes.
module tb_imem_boot_sequencer;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int LW = 16;
   localparam int RC = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          ld_valid = 1'b0;
   logic          ld_ready;
   logic [DW-1:0] ld_data = '0;
   logic          ld_last = 1'b0;
   logic          fetch_req = 1'b0;
   logic [AW-1:0] fetch_addr = '0;
   logic          fetch_gnt;
   logic          fetch_rvalid;
   logic [DW-1:0] fetch_rdata;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          reload_req = 1'b0;
   logic          core_reset;
   logic          load_done;
   logic          load_err;
   logic [AW:0]   loaded_words;

   imem_boot_sequencer #(
      .ADDR_W(AW), .DATA_W(DW),
      .LOAD_WORDS(LW), .RELEASE_CYCLES(RC)
   ) dut (
      .clock(clock), .reset(reset),
      .ld_valid(ld_valid), .ld_ready(ld_ready),
      .ld_data(ld_data), .ld_last(ld_last),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_gnt(fetch_gnt), .fetch_rvalid(fetch_rvalid),
      .fetch_rdata(fetch_rdata),
      .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .reload_req(reload_req),
      .core_reset(core_reset), .load_done(load_done),
      .load_err(load_err), .loaded_words(loaded_words)
   );

   always #5 clock = ~clock;

   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clock) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         mem_rdata <= mem[mem_addr];
      end
   end

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   wr_t           wq[$];
   logic [DW-1:0] rq[$];
   logic [DW-1:0] exp_mem [0:LW-1];
   logic [DW-1:0] img [0:LW-1];
   int            wexp;
   int            n_cmp = 0;
   int            n_mis = 0;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
      end
   endtask

   always @(negedge clock) begin
      if (reset) begin
         if (mem_en && mem_we) begin
            if (wq.size() == 0) begin
               chk("unexpected_write", {54'd0, mem_addr}, 64'hdead);
            end else begin
               wr_t e;
               e = wq.pop_front();
               chk("wr_addr", {54'd0, mem_addr}, {54'd0, e.a});
               chk("wr_data", {32'd0, mem_wdata}, {32'd0, e.d});
            end
         end
         if (fetch_rvalid) begin
            if (rq.size() == 0) begin
               chk("unexpected_rvalid", 64'd1, 64'd0);
            end else begin
               logic [DW-1:0] r;
               r = rq.pop_front();
               chk("rdata", {32'd0, fetch_rdata}, {32'd0, r});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset      = 1'b0;
      ld_valid   = 1'b0;
      ld_last    = 1'b0;
      fetch_req  = 1'b0;
      reload_req = 1'b0;
      wexp       = 0;
      tick();
      tick();
      chk("rst_core_reset", {63'd0, core_reset}, 64'd1);
      chk("rst_load_done", {63'd0, load_done}, 64'd0);
      chk("rst_load_err", {63'd0, load_err}, 64'd0);
      chk("rst_loaded", {53'd0, loaded_words}, 64'd0);
      chk("rst_rvalid", {63'd0, fetch_rvalid}, 64'd0);
      chk("rst_ld_ready", {63'd0, ld_ready}, 64'd1);
      reset = 1'b1;
      tick();
   endtask

   task automatic push_beat(input int i, input logic last);
      wr_t e;
      ld_valid = 1'b1;
      ld_data  = img[i];
      ld_last  = last;
      e.a = AW'(wexp);
      e.d = img[i];
      wq.push_back(e);
      exp_mem[wexp] = img[i];
      wexp++;
      tick();
   endtask

   task automatic load_image(input int n, input logic with_last,
                             input int gap_at, input int gap_len);
      for (int i = 0; i < n; i++) begin
         if (i == gap_at) begin
            ld_valid = 1'b0;
            repeat (gap_len) tick();
         end
         push_beat(i, with_last && (i == n - 1));
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic wait_run(output int cyc);
      cyc = 0;
      while (core_reset && cyc < 50) begin
         tick();
         cyc++;
      end
      chk("run_reached", {63'd0, load_done}, 64'd1);
   endtask

   task automatic fetch_words(input int n);
      for (int a = 0; a < n; a++) begin
         fetch_req  = 1'b1;
         fetch_addr = AW'(a);
         #2;
         chk("fetch_gnt", {63'd0, fetch_gnt}, 64'd1);
         if (fetch_gnt) rq.push_back(exp_mem[a]);
         tick();
      end
      fetch_req = 1'b0;
      tick();
      tick();
      chk("rq_drained", 64'(rq.size()), 64'd0);
   endtask

   task automatic fill_img(input logic [DW-1:0] base,
                           input logic [DW-1:0] step);
      for (int i = 0; i < LW; i++)
         img[i] = base + DW'(i) * step;
   endtask

   initial begin
      int cyc;

      // Image 1 with fetch attempted during load.
      fill_img(32'h0000_0013, 32'h0000_0080);
      do_reset();
      fetch_req  = 1'b1;
      fetch_addr = AW'(5);
      load_image(7, 1'b0, -1, 0);
      chk("gnt_in_load", {63'd0, fetch_gnt}, 64'd0);
      fetch_req = 1'b0;
      push_beat(7, 1'b1);
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      chk("hold_ld_ready", {63'd0, ld_ready}, 64'd0);
      chk("hold_core_reset", {63'd0, core_reset}, 64'd1);
      chk("loaded_8", {53'd0, loaded_words}, 64'd8);
      wait_run(cyc);
      chk("release_latency", 64'(cyc), 64'(RC));
      chk("run_core_reset", {63'd0, core_reset}, 64'd0);
      fetch_words(3);

      // Gap mid-stream, then full readback.
      do_reset();
      load_image(8, 1'b1, 3, 5);
      wait_run(cyc);
      chk("gap_loaded", {53'd0, loaded_words}, 64'd8);
      fetch_words(8);

      // Reset mid-load then a fresh image.
      do_reset();
      load_image(4, 1'b0, -1, 0);
      chk("mid_done", {63'd0, load_done}, 64'd0);
      do_reset();
      fill_img(32'hA5A5_0000, 32'h0001_0001);
      load_image(7, 1'b0, -1, 0);
      tick();
      chk("no_done_early", {63'd0, load_done}, 64'd0);
      push_beat(7, 1'b1);
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      wait_run(cyc);
      chk("reload_loaded", {53'd0, loaded_words}, 64'd8);
      fetch_words(8);

      // Overflow: LW beats without ld_last.
      do_reset();
      load_image(LW, 1'b0, -1, 0);
      chk("err_flag", {63'd0, load_err}, 64'd1);
      chk("err_ld_ready", {63'd0, ld_ready}, 64'd0);
      ld_valid   = 1'b1;
      ld_data    = 32'hFFFF_FFFF;
      fetch_req  = 1'b1;
      fetch_addr = '0;
      #2;
      chk("err_gnt", {63'd0, fetch_gnt}, 64'd0);
      repeat (3) tick();
      ld_valid  = 1'b0;
      fetch_req = 1'b0;
      repeat (RC + 2) tick();
      chk("err_core_reset", {63'd0, core_reset}, 64'd1);
      chk("err_sticky", {63'd0, load_err}, 64'd1);
      chk("err_loaded", {53'd0, loaded_words}, 64'(LW));

      // Exactly LW beats with ld_last is a valid image.
      do_reset();
      fill_img(32'h1234_0000, 32'h0000_0111);
      load_image(LW, 1'b1, -1, 0);
      wait_run(cyc);
      chk("full_no_err", {63'd0, load_err}, 64'd0);
      chk("full_loaded", {53'd0, loaded_words}, 64'(LW));
      fetch_words(LW);

      // Single-beat image.
      do_reset();
      load_image(1, 1'b1, -1, 0);
      wait_run(cyc);
      chk("one_latency", 64'(cyc), 64'(RC));
      fetch_words(1);

      // reload_req in RUN.
      fetch_req  = 1'b1;
      fetch_addr = '0;
      rq.push_back(exp_mem[0]);
      tick();
      reload_req = 1'b1;
      #2;
`ifdef IMEM_RELOAD_EN
      chk("reload_gnt", {63'd0, fetch_gnt}, 64'd0);
      tick();
      reload_req = 1'b0;
      fetch_req  = 1'b0;
      chk("reload_core_reset", {63'd0, core_reset}, 64'd1);
      chk("reload_ld_ready", {63'd0, ld_ready}, 64'd1);
      chk("reload_done", {63'd0, load_done}, 64'd0);
      chk("reload_wptr", {53'd0, loaded_words}, 64'd0);
      wexp = 0;
      fill_img(32'h5EED_0000, 32'h0000_0777);
      load_image(6, 1'b1, -1, 0);
      wait_run(cyc);
      chk("reload_loaded", {53'd0, loaded_words}, 64'd6);
      fetch_words(6);
`else
      chk("reload_ign_gnt", {63'd0, fetch_gnt}, 64'd1);
      if (fetch_gnt) rq.push_back(exp_mem[0]);
      tick();
      reload_req = 1'b0;
      fetch_req  = 1'b0;
      tick();
      chk("reload_ign_rst", {63'd0, core_reset}, 64'd0);
      chk("reload_ign_done", {63'd0, load_done}, 64'd1);
      chk("reload_ign_rdy", {63'd0, ld_ready}, 64'd0);
      chk("reload_ign_cnt", {53'd0, loaded_words}, 64'd1);
`endif
      tick();
      chk("wq_empty", 64'(wq.size()), 64'd0);
      chk("rq_empty", 64'(rq.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_mis);
      $finish;
   end

endmodule
